sys_mem_streamer: RTL
=====================

Name: sys_mem_streamer

Overview:
- Host-side controller for the systemizer matrix memory: the writer/reader counterpart of the systemizer's memory port.
- Loads a full matrix from an inbound byte stream through the systemizer write port, then pulses start and waits for done.
- On success, reads the systemized matrix back through the read port and emits it as an outbound stream.
- Sits between the pin-level top and the systemizer core.

Parameters:
- N, 4, systemizer column-block parameter (passed through to the systemizer, unused here)
- L, 8, matrix rows
- K, 16, matrix columns
- M, 3, field parameter; symbol width SW = CLOG2(M)
- BLOCK, 4, symbols per memory word
- Derived DEPTH = L*K/BLOCK (32), AW = CLOG2(DEPTH) (5), DW = BLOCK*SW (8)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- go  in  1  one-cycle pulse that starts a job; ignored unless idle
- s_data  in  DW  inbound matrix word
- s_valid  in  1  inbound word valid
- s_ready  out  1  inbound ready
- m_data  out  DW  outbound result word
- m_valid  out  1  outbound valid
- m_ready  in  1  outbound ready
- busy  out  1  high whenever state is not IDLE
- err  out  1  sticky: last job failed; cleared by the next accepted go
- sys_wr_en  out  1  systemizer write enable
- sys_wr_addr  out  AW  systemizer write address
- sys_data_in  out  DW  systemizer write data
- sys_start  out  1  systemizer start pulse
- sys_rd_en  out  1  systemizer read enable
- sys_rd_addr  out  AW  systemizer read address
- sys_data_out  in  DW  systemizer read data; valid exactly 1 cycle after sys_rd_en
- sys_done  in  1  systemizer done
- sys_fail  in  1  systemizer fail
- sys_success  in  1  systemizer success

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; counters 0; skid buffer empty; err 0.
- IDLE: s_ready=0. On go: clear err, wr_ptr=0, go to LOAD.
- LOAD:
  - s_ready=1.
  - Each s_valid&&s_ready beat: sys_wr_en=1, sys_wr_addr=wr_ptr, sys_data_in=s_data in that same cycle (combinational pass-through, zero latency); wr_ptr increments.
  - When the beat at DEPTH-1 is accepted, go to START next cycle. No beats are accepted after it.
- START: sys_start=1 for exactly one cycle, then WAIT.
- WAIT:
  - Poll sys_done.
  - On done with sys_success=1: rd_ptr=0, go to DRAIN.
  - On done with sys_fail=1, or with neither flag set: err=1, go to IDLE.
  - If fail and success are both high, fail wins.
- DRAIN: 2-entry output FIFO (skid buffer).
  - Issue sys_rd_en with sys_rd_addr=rd_ptr only while rd_ptr<DEPTH and (fifo_count + reads_in_flight) < 2.
  - Returning sys_data_out is pushed into the FIFO the cycle after the read.
  - m_valid = FIFO non-empty; m_data = FIFO head.
  - A simultaneous push and pop keeps the count unchanged.
  - Leave to IDLE the cycle after the DEPTH-th word is popped.
- Backpressure: m_ready held low indefinitely stalls reads with no loss or duplication; words emerge in address order 0..DEPTH-1.
- go while busy: ignored.
- s_valid outside LOAD: ignored, no write.
- Reset mid-job: everything returns to reset values immediately; partial writes to the systemizer memory are not undone.
- sys_wr_en and sys_rd_en are never high in the same cycle.
- Pointers are AW+1 bits, so DEPTH is detectable without wrap ambiguity.

Decomposition:
- Shared package: state enum (IDLE, LOAD, START, WAIT, DRAIN), DEPTH/AW/DW derivation, and CLOG2 via the existing clog2 include.
- One sub-module: sms_skid_fifo (2-entry, DW wide, push/pop/count).

Test Plan:
- Load words 0x00..0x1F with m_ready=1; systemizer model asserts done+success 10 cycles after start -> sys_wr_addr sequence 0..31, exactly one sys_start pulse, m_data streams 0x1F^addr (model inverts) in order 0..31, busy drops, err=0.
- s_valid toggled every other cycle during LOAD -> exactly 32 writes, no duplicate addresses, sys_start exactly one cycle after the 32nd beat.
- DRAIN with m_ready random at 30% -> all 32 words delivered once, in order; fifo_count never exceeds 2; no sys_rd_en while count+in-flight=2.
- Model asserts done+fail -> err=1, state IDLE, no sys_rd_en ever; next go clears err.
- rst_n pulsed low at write 12 -> all outputs 0 in the same cycle; a subsequent go restarts loading at address 0.
- go pulsed during WAIT and DRAIN -> ignored; the job completes normally.

Source files
------------

// File: rtl/sys_mem_streamer_pkg.sv
// Shared types and sizing for the systemizer memory streamer.
package sys_mem_streamer_pkg;

    // Ceiling log2 used to size symbol and address fields.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int unsigned N     = 4;   // systemizer column-block size, not used by the streamer
    localparam int unsigned L     = 8;
    localparam int unsigned K     = 16;
    localparam int unsigned M     = 3;
    localparam int unsigned SW    = clog2(M);
    localparam int unsigned BLOCK = 4;
    localparam int unsigned DEPTH = L * K / BLOCK;
    localparam int unsigned AW    = clog2(DEPTH);
    localparam int unsigned DW    = BLOCK * SW;
    localparam int unsigned PW    = AW + 1;   // one extra bit so DEPTH itself is representable

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_DRAIN
    } state_t;

    // Write-port payload towards the systemizer memory.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } mem_wr_t;

endpackage

// File: rtl/sys_mem_streamer_skid_fifo.sv
// Two-entry output skid buffer; head is always in r_d0.
module sms_skid_fifo
    import sys_mem_streamer_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic [DW-1:0] i_data,
    input  logic          i_pop,
    output logic [1:0]    o_count,
    output logic [DW-1:0] o_head
);

    logic [DW-1:0] r_d0;
    logic [DW-1:0] r_d1;
    logic [1:0]    r_count;

    // Storage and occupancy; pops are only issued when non-empty, pushes only when not full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d0    <= '0;
            r_d1    <= '0;
            r_count <= '0;
        end else begin
            unique case ({i_push, i_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_d0 <= i_data;
                    else                 r_d1 <= i_data;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_d0    <= r_d1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd1) begin
                        r_d0 <= i_data;
                    end else begin
                        r_d0 <= r_d1;
                        r_d1 <= i_data;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_d0;

endmodule

// File: rtl/sys_mem_streamer.sv
// Host-side loader/unloader for the systemizer matrix memory.
module sys_mem_streamer
    import sys_mem_streamer_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          go,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    output logic [DW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic          busy,
    output logic          err,
    output logic          sys_wr_en,
    output logic [AW-1:0] sys_wr_addr,
    output logic [DW-1:0] sys_data_in,
    output logic          sys_start,
    output logic          sys_rd_en,
    output logic [AW-1:0] sys_rd_addr,
    input  logic [DW-1:0] sys_data_out,
    input  logic          sys_done,
    input  logic          sys_fail,
    input  logic          sys_success
);

    state_t        r_state;
    state_t        w_next;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic          r_inflight;
    logic          r_err;
    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_pop;
    logic          w_ok;
    logic [1:0]    w_count;
    logic [DW-1:0] w_head;
    mem_wr_t       w_wr;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next;
    end

    // Next state plus the write/read issue decisions.
    always_comb begin
        w_next  = r_state;
        w_wr_en = 1'b0;
        w_rd_en = 1'b0;
        w_ok    = sys_success && !sys_fail;
        unique case (r_state)
            ST_IDLE: begin
                if (go) w_next = ST_LOAD;
            end
            ST_LOAD: begin
                w_wr_en = s_valid;
                if (s_valid && (r_wr_ptr == PW'(DEPTH - 1))) w_next = ST_START;
            end
            ST_START: begin
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (sys_done) w_next = w_ok ? ST_DRAIN : ST_IDLE;
            end
            ST_DRAIN: begin
                // Credit: buffered words plus the read still returning must leave a free slot.
                w_rd_en = (r_rd_ptr < PW'(DEPTH)) &&
                          ((3'(w_count) + 3'(r_inflight)) < 3'd2);
                if (w_pop && (w_count == 2'd1) && !r_inflight && (r_rd_ptr == PW'(DEPTH)))
                    w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Pointers, read-return tracking and the sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_inflight <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_inflight <= w_rd_en;
            if ((r_state == ST_IDLE) && go) begin
                r_err    <= 1'b0;
                r_wr_ptr <= '0;
            end
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + PW'(1);
            if ((r_state == ST_WAIT) && sys_done) begin
                if (w_ok) r_rd_ptr <= '0;
                else      r_err    <= 1'b1;
            end
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    sms_skid_fifo u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_inflight),
        .i_data  (sys_data_out),
        .i_pop   (w_pop),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign w_pop        = m_valid && m_ready;
    assign w_wr.addr    = w_wr_en ? r_wr_ptr[AW-1:0] : '0;
    assign w_wr.data    = w_wr_en ? s_data : '0;

    assign s_ready      = (r_state == ST_LOAD);
    assign sys_wr_en    = w_wr_en;
    assign sys_wr_addr  = w_wr.addr;
    assign sys_data_in  = w_wr.data;
    assign sys_start    = (r_state == ST_START);
    assign sys_rd_en    = w_rd_en;
    assign sys_rd_addr  = w_rd_en ? r_rd_ptr[AW-1:0] : '0;
    assign m_valid      = (w_count != 2'd0);
    assign m_data       = w_head;
    assign busy         = (r_state != ST_IDLE);
    assign err          = r_err;

endmodule
